// File: rtl/adder_pkg.sv
// Shared types and helpers for the pipelined add/subtract unit.
//   adder_op_t  : per-beat operation (add / subtract)
//   chunk_w()   : carry-chain segment width for a WIDTH/STAGES split
//   adder_ctl_t : per-stage control record (valid, op, saturate, carry).
//                 The width-dependent part of the record (remaining
//                 operands, partial sum) lives beside it in the top as
//                 WIDTH-bit arrays, because a package struct cannot take
//                 the module's WIDTH parameter.
package adder_pkg;

  typedef enum logic {ADDER_OP_ADD = 1'b0, ADDER_OP_SUB = 1'b1} adder_op_t;

  function automatic int chunk_w(input int width, input int stages);
    return width / stages;
  endfunction

  typedef struct packed {
    logic      valid;
    adder_op_t op;
    logic      sat;
    logic      carry;
  } adder_ctl_t;

endpackage

// File: rtl/adder_chunk.sv
// Combinational W-bit adder segment.
//   a, b   : segment operands (b already inverted for subtract)
//   cin    : carry into bit 0
//   sum    : segment sum
//   cout   : carry out of the segment MSB
//   c_msb  : carry into the segment MSB (cout ^ c_msb = signed overflow)
module adder_chunk #(
  parameter int W = 8
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         cin,
  output logic [W-1:0] sum,
  output logic         cout,
  output logic         c_msb
);

  logic [W:0] full;

  assign full  = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, cin};
  assign sum   = full[W-1:0];
  assign cout  = full[W];
  // sum bit = a ^ b ^ carry-in, so the MSB carry-in falls out directly
  assign c_msb = a[W-1] ^ b[W-1] ^ sum[W-1];

endmodule

// File: rtl/pipelined_adder.sv
// Pipelined add/subtract unit. The WIDTH-bit carry chain is cut into
// STAGES segments of WIDTH/STAGES bits; stage s adds segment s using the
// carry registered by stage s-1. Operands and finished low segments ride
// along in registers. Latency STAGES, throughput 1 beat/cycle, global
// stall when the output is valid and not taken.
//
// Ports:
//   clk, reset           : clock, synchronous active-high reset
//   in_valid / in_ready  : input handshake (in_ready = pipeline advances)
//   a, b, op_sub         : operands, 0 = add, 1 = subtract
//   op_sat               : saturate on overflow (PIPELINED_ADDER_SAT_EN only)
//   out_valid / out_ready: output handshake
//   y, cout, ovf, zero   : result, carry-out (sub: 1 = no borrow),
//                          signed overflow, y == 0
//
// Build option: define PIPELINED_ADDER_SAT_EN to add the op_sat input and
// clamp overflowing results to the signed min/max.
module pipelined_adder
  import adder_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter int STAGES = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             op_sub,
`ifdef PIPELINED_ADDER_SAT_EN
  input  logic             op_sat,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] y,
  output logic             cout,
  output logic             ovf,
  output logic             zero
);

  localparam int CHUNK = chunk_w(WIDTH, STAGES);

  if (STAGES < 1 || STAGES > WIDTH || (WIDTH % STAGES) != 0) begin : g_bad_cfg
    $error("pipelined_adder: WIDTH must be a multiple of STAGES, 1 <= STAGES <= WIDTH");
  end

  // stage inputs (_i) and stage registers (_q), one entry per stage
  adder_ctl_t       ctl_i [STAGES];
  adder_ctl_t       ctl_q [STAGES];
  logic [WIDTH-1:0] a_i   [STAGES];
  logic [WIDTH-1:0] b_i   [STAGES];
  logic [WIDTH-1:0] s_i   [STAGES];
  logic [WIDTH-1:0] a_q   [STAGES];
  logic [WIDTH-1:0] b_q   [STAGES];
  logic [WIDTH-1:0] s_q   [STAGES];
  logic             ovf_q, zero_q;
  logic             adv;

  // single enable for every stage: bubbles are held, not collapsed
  assign adv      = !ctl_q[STAGES-1].valid || out_ready;
  assign in_ready = adv;

  for (genvar s = 0; s < STAGES; s++) begin : g_stage
    logic [CHUNK-1:0] csum;
    logic             ccout, cmsb;
    logic [WIDTH-1:0] s_nxt, s_out;
    adder_ctl_t       ctl_nxt;

    if (s == 0) begin : g_in
      logic sat_in;
`ifdef PIPELINED_ADDER_SAT_EN
      assign sat_in = op_sat;
`else
      assign sat_in = 1'b0;
`endif
      // subtract = a + ~b + 1; the +1 enters as stage-0 carry-in
      assign ctl_i[0] = '{valid: in_valid, op: adder_op_t'(op_sub),
                          sat: sat_in, carry: op_sub};
      assign a_i[0]   = a;
      assign b_i[0]   = op_sub ? ~b : b;
      assign s_i[0]   = '0;
    end else begin : g_fwd
      assign ctl_i[s] = ctl_q[s-1];
      assign a_i[s]   = a_q[s-1];
      assign b_i[s]   = b_q[s-1];
      assign s_i[s]   = s_q[s-1];
    end

    adder_chunk #(.W(CHUNK)) u_chunk (
      .a     (a_i[s][s*CHUNK +: CHUNK]),
      .b     (b_i[s][s*CHUNK +: CHUNK]),
      .cin   (ctl_i[s].carry),
      .sum   (csum),
      .cout  (ccout),
      .c_msb (cmsb)
    );

    always_comb begin
      s_nxt = s_i[s];
      s_nxt[s*CHUNK +: CHUNK] = csum;
      ctl_nxt       = ctl_i[s];
      ctl_nxt.carry = ccout;
    end

    if (s == STAGES-1) begin : g_last
      logic ovf_nxt, zero_nxt;
      logic [WIDTH-1:0] y_fin;

      always_comb begin
        ovf_nxt = ccout ^ cmsb;
        y_fin   = s_nxt;
        // clamp toward the sign of a: positive overflow -> max, negative -> min
        if (ctl_i[s].sat && ovf_nxt) begin
          if (a_i[s][WIDTH-1]) begin
            y_fin = '0;
            y_fin[WIDTH-1] = 1'b1;
          end else begin
            y_fin = '1;
            y_fin[WIDTH-1] = 1'b0;
          end
        end
        zero_nxt = (y_fin == '0);
      end

      assign s_out = y_fin;

      always_ff @(posedge clk) begin
        if (reset) begin
          ovf_q  <= 1'b0;
          zero_q <= 1'b0;
        end else if (adv) begin
          ovf_q  <= ovf_nxt;
          zero_q <= zero_nxt;
        end
      end
    end else begin : g_mid
      assign s_out = s_nxt;
    end

    always_ff @(posedge clk) begin
      if (reset) begin
        ctl_q[s] <= '0;
        a_q[s]   <= '0;
        b_q[s]   <= '0;
        s_q[s]   <= '0;
      end else if (adv) begin
        ctl_q[s] <= ctl_nxt;
        a_q[s]   <= a_i[s];
        b_q[s]   <= b_i[s];
        s_q[s]   <= s_out;
      end
    end
  end

  assign out_valid = ctl_q[STAGES-1].valid;
  assign y         = s_q[STAGES-1];
  assign cout      = ctl_q[STAGES-1].carry;
  assign ovf       = ovf_q;
  assign zero      = zero_q;

endmodule

// File: tb/tb_pipelined_adder.sv
// Directed bench for pipelined_adder: main 32/4 instance plus 8/1 and
// 64/8 instances for the degenerate and deep configurations.
module tb_pipelined_adder;

`ifdef PIPELINED_ADDER_SAT_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  // main instance, WIDTH=32 STAGES=4
  logic        in_valid, in_ready, op_sub, op_sat, out_valid, out_ready;
  logic [31:0] a, b, y;
  logic        cout, ovf, zero;

  pipelined_adder #(.WIDTH(32), .STAGES(4)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .op_sub(op_sub),
`ifdef PIPELINED_ADDER_SAT_EN
    .op_sat(op_sat),
`endif
    .out_valid(out_valid), .out_ready(out_ready),
    .y(y), .cout(cout), .ovf(ovf), .zero(zero)
  );

  // WIDTH=8 STAGES=1
  logic       d1_iv, d1_ir, d1_sub, d1_sat, d1_ov, d1_or, d1_c, d1_o, d1_z;
  logic [7:0] d1_a, d1_b, d1_y;

  pipelined_adder #(.WIDTH(8), .STAGES(1)) dut1 (
    .clk(clk), .reset(reset), .in_valid(d1_iv), .in_ready(d1_ir),
    .a(d1_a), .b(d1_b), .op_sub(d1_sub),
`ifdef PIPELINED_ADDER_SAT_EN
    .op_sat(d1_sat),
`endif
    .out_valid(d1_ov), .out_ready(d1_or),
    .y(d1_y), .cout(d1_c), .ovf(d1_o), .zero(d1_z)
  );

  // WIDTH=64 STAGES=8
  logic        d8_iv, d8_ir, d8_sub, d8_sat, d8_ov, d8_or, d8_c, d8_o, d8_z;
  logic [63:0] d8_a, d8_b, d8_y;

  pipelined_adder #(.WIDTH(64), .STAGES(8)) dut8 (
    .clk(clk), .reset(reset), .in_valid(d8_iv), .in_ready(d8_ir),
    .a(d8_a), .b(d8_b), .op_sub(d8_sub),
`ifdef PIPELINED_ADDER_SAT_EN
    .op_sat(d8_sat),
`endif
    .out_valid(d8_ov), .out_ready(d8_or),
    .y(d8_y), .cout(d8_c), .ovf(d8_o), .zero(d8_z)
  );

  int checks = 0;
  int errors = 0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, got, exp);
    end
  endtask

  // one beat through the 32/4 instance with a bounded wait for the result
  task automatic run_one(input string tag, input logic [31:0] ta, input logic [31:0] tb,
                         input logic sub, input logic sat, input logic [31:0] ey,
                         input logic ec, input logic eo, input logic ez);
    int lat;
    in_valid = 1'b1; a = ta; b = tb; op_sub = sub; op_sat = sat;
    tick();
    in_valid = 1'b0; op_sat = 1'b0;
    lat = 1;
    while (!out_valid && lat < 20) begin
      tick();
      lat++;
    end
    chk({tag, ".lat"},  lat,  4);
    chk({tag, ".y"},    y,    ey);
    chk({tag, ".cout"}, cout, ec);
    chk({tag, ".ovf"},  ovf,  eo);
    chk({tag, ".zero"}, zero, ez);
    tick();
  endtask

  task automatic d1_one(input string tag, input logic [7:0] ta, input logic [7:0] tb,
                        input logic sub, input logic sat, input logic [7:0] ey,
                        input logic ec, input logic eo, input logic ez);
    d1_iv = 1'b1; d1_a = ta; d1_b = tb; d1_sub = sub; d1_sat = sat;
    tick();
    d1_iv = 1'b0; d1_sat = 1'b0;
    chk({tag, ".vld"},  d1_ov, 1'b1);
    chk({tag, ".y"},    d1_y,  ey);
    chk({tag, ".cout"}, d1_c,  ec);
    chk({tag, ".ovf"},  d1_o,  eo);
    chk({tag, ".zero"}, d1_z,  ez);
    tick();
  endtask

  task automatic d8_one(input string tag, input logic [63:0] ta, input logic [63:0] tb,
                        input logic sub, input logic [63:0] ey,
                        input logic ec, input logic eo, input logic ez);
    int lat;
    d8_iv = 1'b1; d8_a = ta; d8_b = tb; d8_sub = sub;
    tick();
    d8_iv = 1'b0;
    lat = 1;
    while (!d8_ov && lat < 30) begin
      tick();
      lat++;
    end
    chk({tag, ".lat"},  lat,  8);
    chk({tag, ".y"},    d8_y, ey);
    chk({tag, ".cout"}, d8_c, ec);
    chk({tag, ".ovf"},  d8_o, eo);
    chk({tag, ".zero"}, d8_z, ez);
    tick();
  endtask

  initial begin
    logic [31:0] exp_q[$];
    logic [31:0] hold_y, ra, rb, ry;
    logic        rs, rc, ro, stalled_prev, seen;
    int          sent, got, stall_cnt;

    reset = 1'b1;
    in_valid = 0; a = 0; b = 0; op_sub = 0; op_sat = 0; out_ready = 1;
    d1_iv = 0; d1_a = 0; d1_b = 0; d1_sub = 0; d1_sat = 0; d1_or = 1;
    d8_iv = 0; d8_a = 0; d8_b = 0; d8_sub = 0; d8_sat = 0; d8_or = 1;
    tick();
    tick();
    reset = 1'b0;
    #1;

    // reset state
    chk("rst.out_valid", out_valid, 0);
    chk("rst.y",         y,         0);
    chk("rst.cout",      cout,      0);
    chk("rst.ovf",       ovf,       0);
    chk("rst.zero",      zero,      0);
    chk("rst.in_ready",  in_ready,  1);

    // directed vectors, 32/4
    run_one("ripple",   32'hFFFF_FFFF, 32'h1, 0, 0, 32'h0, 1, 0, 1);
    run_one("ovf_pos",  32'h7FFF_FFFF, 32'h1, 0, SAT,
            SAT ? 32'h7FFF_FFFF : 32'h8000_0000, 0, 1, 0);
    run_one("sub_neg",  32'h5, 32'h7, 1, 0, 32'hFFFF_FFFE, 0, 0, 0);
    run_one("sub_pos",  32'h7, 32'h5, 1, 0, 32'h2, 1, 0, 0);
    run_one("ovf_neg",  32'h8000_0000, 32'h1, 1, SAT,
            SAT ? 32'h8000_0000 : 32'h7FFF_FFFF, 1, 1, 0);
    run_one("sub_zero", 32'h0, 32'h0, 1, 0, 32'h0, 1, 0, 1);
    run_one("chunk_x",  32'h0000_FFFF, 32'h1, 0, 0, 32'h0001_0000, 0, 0, 0);

    // random operands against an arithmetic reference
    for (int i = 0; i < 12; i++) begin
      ra = $urandom;
      rb = (i == 3) ? ra : $urandom;
      rs = 1'($urandom_range(0, 1));
      if (rs) begin
        ry = ra - rb;
        rc = (ra >= rb);
        ro = (ra[31] != rb[31]) && (ry[31] != ra[31]);
      end else begin
        {rc, ry} = {1'b0, ra} + {1'b0, rb};
        ro = (ra[31] == rb[31]) && (ry[31] != ra[31]);
      end
      run_one("rand", ra, rb, rs, 0, ry, rc, ro, ry == 32'h0);
    end

    // 8 back-to-back beats, consumer stalls on cycles 6..9
    sent = 0; got = 0; stall_cnt = 0; stalled_prev = 0; hold_y = 0;
    for (int c = 0; c < 40 && got < 8; c++) begin
      out_ready = !(c >= 6 && c <= 9);
      in_valid  = (sent < 8);
      a = 32'h1111_1111 * sent;
      b = 32'hF0F0_F0F0 ^ sent;
      op_sub = 1'b0;
      #1;
      if (out_valid && !out_ready) begin
        stall_cnt++;
        chk("stall.in_ready", in_ready, 0);
      end
      if (stalled_prev) chk("stall.hold_y", y, hold_y);
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) chk("stream.extra", out_valid, 0);
        else chk("stream.y", y, exp_q.pop_front());
        got++;
      end
      stalled_prev = out_valid && !out_ready;
      hold_y = y;
      if (in_valid && in_ready) begin
        exp_q.push_back(a + b);
        sent++;
      end
      tick();
    end
    in_valid = 0; out_ready = 1;
    chk("stream.count", got, 8);
    chk("stream.stalls", stall_cnt, 4);
    seen = 0;
    for (int c = 0; c < 6; c++) begin
      seen |= out_valid;
      tick();
    end
    chk("stream.drain", seen, 0);

    // reset with three beats in flight
    for (int i = 0; i < 3; i++) begin
      in_valid = 1; a = 32'h100 + i; b = 32'h1; op_sub = 0;
      tick();
    end
    in_valid = 0;
    reset = 1;
    tick();
    reset = 0;
    chk("flush.out_valid", out_valid, 0);
    chk("flush.y", y, 0);
    seen = 0;
    for (int c = 0; c < 6; c++) begin
      seen |= out_valid;
      tick();
    end
    chk("flush.stale", seen, 0);
    run_one("after_rst", 32'h3, 32'h4, 0, 0, 32'h7, 0, 0, 0);

    // STAGES=1, WIDTH=8
    d1_one("w8.ripple", 8'hFF, 8'h01, 0, 0, 8'h00, 1, 0, 1);
    d1_one("w8.ovf",    8'h7F, 8'h01, 0, SAT, SAT ? 8'h7F : 8'h80, 0, 1, 0);
    d1_one("w8.subovf", 8'h80, 8'h01, 1, SAT, SAT ? 8'h80 : 8'h7F, 1, 1, 0);

    // STAGES=8, WIDTH=64
    d8_one("w64.ripple", 64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 0, 64'h0, 1, 0, 1);
    d8_one("w64.borrow", 64'h0, 64'h1, 1, 64'hFFFF_FFFF_FFFF_FFFF, 0, 0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pipelined_adder.md
Name: pipelined_adder

Overview:
- Parameterised, pipelined add/subtract unit. Splits the WIDTH-bit carry chain into STAGES equal chunks, one chunk per pipeline stage.
- Supports add or subtract per transaction, with carry-out, signed overflow and zero flags.
- Uses a valid/ready handshake on both sides with backpressure.
- Target use: wide address/accumulator arithmetic in the execute path and multi-cycle arithmetic blocks where a single-cycle WIDTH-bit carry chain misses timing.

Parameters:
- WIDTH, 32, data width in bits; must be a multiple of STAGES (elaboration-time assertion).
- STAGES, 4, pipeline depth and carry-chain segment count; 1..WIDTH. CHUNK = WIDTH/STAGES.

Ports:
- clk  input  1  clock, rising edge
- reset  input  1  synchronous, active-high reset
- in_valid  input  1  operand beat valid
- in_ready  output  1  block can accept a beat this cycle
- a  input  WIDTH  operand A
- b  input  WIDTH  operand B
- op_sub  input  1  0: y = a + b; 1: y = a - b
- out_valid  output  1  result beat valid
- out_ready  input  1  consumer accepts the result
- y  output  WIDTH  sum/difference, modulo 2^WIDTH
- cout  output  1  carry-out of MSB (for subtract: 1 = no borrow)
- ovf  output  1  signed two's-complement overflow
- zero  output  1  y == 0

Behaviour:
- Reset: clk and reset only, synchronous, active-high. Every stage valid bit and all data/carry registers clear to 0. Outputs after reset: out_valid=0, y=0, cout=0, ovf=0, zero=0. in_ready=1 while reset is low.
- Reset mid-operation flushes every in-flight beat; no result for those beats is ever presented.
- Subtract is implemented as a + ~b with carry-in 1. op_sub travels with the beat.
- Stage s (0..STAGES-1) adds chunk s of A and B' with the carry registered from stage s-1 (stage 0 carry-in = op_sub).
- Unprocessed upper chunks and already-computed lower sum chunks are skewed forward in registers alongside the beat.
- Latency: exactly STAGES cycles from accept (in_valid && in_ready) to out_valid with no backpressure. Throughput is 1 beat/cycle.
- Global advance enable: adv = !out_valid || out_ready. in_ready = adv. When adv=0 all stages hold, including bubbles (no bubble collapse).
- Output holds stable (y, cout, ovf, zero, out_valid) while out_valid && !out_ready.
- ovf = (a[MSB] == b'[MSB]) && (y[MSB] != a[MSB]), where b' is the inverted b for subtract.
- zero is computed from the final y in the last stage, registered with it.
- Simultaneous accept and output handshake in the same cycle is legal and lossless.
- in_valid=0 inserts a bubble; the valid bit propagates as 0 and data registers may update freely.
- STAGES=1: a plain registered adder with latency 1.

Optional Feature:
- Macro: PIPELINED_ADDER_SAT_EN.
- Defined: adds input op_sat (1 bit, travels with the beat). When op_sat=1 and ovf=1, y clamps in the final stage to 0x7FF..F if a[MSB]=0, else 0x800..0. ovf still reports the overflow, and zero reflects the clamped y.
- Undefined: no op_sat port; y always wraps.

Decomposition:
- Shared package adder_pkg:
  - typedef enum logic {ADDER_OP_ADD, ADDER_OP_SUB} adder_op_t
  - localparam helper for CHUNK computation
  - struct for the per-stage pipeline record (valid, op, carry, partial sum, remaining operands)
- One sub-module: adder_chunk, a combinational CHUNK-bit adder with cin/cout and MSB carry-in exposed for overflow. It is instantiated STAGES times in a generate loop.

Test Plan:
- WIDTH=32, STAGES=4: a=0xFFFF_FFFF, b=1, add → after 4 cycles y=0, cout=1, zero=1, ovf=0 (carry ripples across all chunks).
- a=0x7FFF_FFFF, b=1, add → y=0x8000_0000, ovf=1, cout=0. Under PIPELINED_ADDER_SAT_EN with op_sat=1 → y=0x7FFF_FFFF, ovf=1.
- a=5, b=7, subtract → y=0xFFFF_FFFE, cout=0, ovf=0. a=7, b=5, subtract → y=2, cout=1.
- Stream 8 back-to-back beats with out_ready held 0 from cycle 6 to 9:
  - in_ready drops at the same time.
  - No beat is lost or duplicated, and order is preserved.
  - y stays stable while stalled.
- Assert reset for 1 cycle with 3 beats in flight → out_valid=0 the next cycle, no stale results appear, and a new beat completes with latency 4.
- Random regression at STAGES ∈ {1, 2, 8}, WIDTH ∈ {8, 32, 64}, with random in_valid/out_ready: scoreboard y/cout/ovf/zero against a reference a±b model.
